// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Single-entry fetch/decode pipeline stage. The PC register drives the
//   instruction memory address. Each accepted instruction word is decoded and
//   captured into a registered output entry, which is held until downstream
//   takes it. A redirect reloads the PC and flushes the held entry.
//
// Parameters
//   XLEN      PC/address width (32..64)
//   RESET_PC  PC value loaded by reset (4-byte aligned)
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   imem_addr         fetch address (current PC)
//   imem_data/valid   instruction word for imem_addr, same cycle
//   redirect_valid/pc branch/jump redirect; highest priority
//   out_valid/ready   handshake for the held decoded entry
//   out_pc .. out_imm registered fields of the held entry
//   out_type          one-hot {j,u,b,s,i,r}
//   out_illegal       entry failed decode (includes misaligned fetch)
//   out_misaligned    entry fetched from a PC with pc[1:0] != 0
module fetch_decode_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            imem_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_type,
    output logic            out_illegal,
    output logic            out_misaligned
);

    // Bit positions inside the one-hot type vector.
    localparam int unsigned T_R = 0;
    localparam int unsigned T_I = 1;
    localparam int unsigned T_S = 2;
    localparam int unsigned T_B = 3;
    localparam int unsigned T_U = 4;
    localparam int unsigned T_J = 5;

    logic [XLEN-1:0] pc;
    logic            accept;
    logic            misaligned_d;
    logic            illegal_d;
    logic [5:0]      type_d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;

    assign imem_addr = pc;
    assign accept    = imem_valid & ~redirect_valid & (~out_valid | out_ready);

    // Decode of the word currently presented by instruction memory.
    always_comb begin
        type_d       = '0;
        imm32        = '0;
        misaligned_d = (pc[1:0] != 2'b00);

        casez (imem_data[6:2])
            5'b011?0, 5'b01011, 5'b10100: type_d[T_R] = 1'b1;
            5'b0000?, 5'b001?0, 5'b11001: type_d[T_I] = 1'b1;
            5'b0100?:                     type_d[T_S] = 1'b1;
            5'b11000:                     type_d[T_B] = 1'b1;
            5'b0?101:                     type_d[T_U] = 1'b1;
            5'b11011:                     type_d[T_J] = 1'b1;
            default:                      type_d      = '0;
        endcase

        // A misaligned fetch is reported as illegal; an illegal entry
        // carries no type and a zero immediate.
        illegal_d = (imem_data[1:0] != 2'b11) || (type_d == '0) || misaligned_d;
        if (illegal_d) begin
            type_d = '0;
        end

        unique case (1'b1)
            type_d[T_I]: imm32 = {{20{imem_data[31]}}, imem_data[31:20]};
            type_d[T_S]: imm32 = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
            type_d[T_B]: imm32 = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                                  imem_data[30:25], imem_data[11:8], 1'b0};
            type_d[T_U]: imm32 = {imem_data[31:12], 12'b0};
            type_d[T_J]: imm32 = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                                  imem_data[20], imem_data[30:21], 1'b0};
            default:     imm32 = '0;
        endcase

        imm_d = XLEN'($signed(imm32));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_instr      <= '0;
            out_opcode     <= '0;
            out_funct3     <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_imm        <= '0;
            out_type       <= '0;
            out_illegal    <= 1'b0;
            out_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            // Flush: the held fields stay as they are but are no longer valid.
            pc        <= redirect_pc;
            out_valid <= 1'b0;
        end else if (accept) begin
            pc             <= pc + XLEN'(4);
            out_valid      <= 1'b1;
            out_pc         <= pc;
            out_instr      <= imem_data;
            out_opcode     <= imem_data[6:0];
            out_funct3     <= imem_data[14:12];
            out_rd         <= imem_data[11:7];
            out_rs1        <= imem_data[19:15];
            out_rs2        <= imem_data[24:20];
            out_imm        <= imm_d;
            out_type       <= type_d;
            out_illegal    <= illegal_d;
            out_misaligned <= misaligned_d;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the stage kept in this file.
module tb_fetch_decode_stage;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            imem_valid;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [5:0]      out_type;
    logic            out_illegal;
    logic            out_misaligned;

    fetch_decode_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_opcode     (out_opcode),
        .out_funct3     (out_funct3),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_imm        (out_imm),
        .out_type       (out_type),
        .out_illegal    (out_illegal),
        .out_misaligned (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state: PC plus the held entry as plain values.
    logic [XLEN-1:0] m_pc;
    logic            m_valid;
    logic [XLEN-1:0] m_out_pc;
    logic [31:0]     m_instr;
    logic [5:0]      m_type;
    logic [63:0]     m_imm;
    logic            m_ill;
    logic            m_mis;

    localparam logic [63:0] XMASK = {64{1'b1}} >> (64 - XLEN);

    // Reference decode from full 7-bit opcodes and integer arithmetic.
    function automatic void ref_decode(input logic [31:0] ins, input logic mis,
                                       output logic [5:0] ty, output logic [63:0] imm,
                                       output logic ill);
        longint s;
        logic [6:0] op;
        op  = ins[6:0];
        s   = longint'($signed(ins));
        ty  = 6'h00;
        imm = 64'h0;
        if (op inside {7'h33, 7'h3B, 7'h53, 7'h2F})                 ty = 6'h01;
        else if (op inside {7'h03, 7'h07, 7'h13, 7'h1B, 7'h67})     ty = 6'h02;
        else if (op inside {7'h23, 7'h27})                          ty = 6'h04;
        else if (op == 7'h63)                                       ty = 6'h08;
        else if (op inside {7'h37, 7'h17})                          ty = 6'h10;
        else if (op == 7'h6F)                                       ty = 6'h20;
        ill = mis || (ty == 6'h00);
        if (ill) ty = 6'h00;
        case (ty)
            6'h02: imm = 64'(s >>> 20);
            6'h04: imm = 64'((s >>> 25) * 32 + longint'(ins[11:7]));
            6'h08: imm = 64'((s >>> 31) * 4096 + longint'(ins[7]) * 2048
                             + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2);
            6'h10: imm = 64'(longint'($signed(ins & 32'hFFFF_F000)));
            6'h20: imm = 64'((s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                             + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2);
            default: imm = 64'h0;
        endcase
        imm = imm & XMASK;
    endfunction

    // One clock: drive inputs after the falling edge, advance the model by the
    // stage's rules, then compare everything just after the rising edge.
    task automatic cyc(input logic rst, input logic iv, input logic [31:0] d,
                       input logic rv, input logic [XLEN-1:0] rp, input logic rdy);
        @(negedge clk);
        reset          = rst;
        imem_valid     = iv;
        imem_data      = d;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        #1;
        check("imem_addr_pre", 64'(imem_addr), 64'(m_pc));
        if (rst) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_out_pc = '0; m_instr = '0;
            m_type = '0; m_imm = '0; m_ill = 1'b0; m_mis = 1'b0;
        end else if (rv) begin
            m_pc    = rp;
            m_valid = 1'b0;
        end else if (iv && (!m_valid || rdy)) begin
            m_out_pc = m_pc;
            m_instr  = d;
            m_mis    = (m_pc % 4) != 0;
            ref_decode(d, m_mis, m_type, m_imm, m_ill);
            m_valid  = 1'b1;
            m_pc     = m_pc + 4;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid",      64'(out_valid),      64'(m_valid));
        check("imem_addr",      64'(imem_addr),      64'(m_pc));
        check("out_pc",         64'(out_pc),         64'(m_out_pc));
        check("out_instr",      64'(out_instr),      64'(m_instr));
        check("out_opcode",     64'(out_opcode),     64'(m_instr & 32'h7F));
        check("out_funct3",     64'(out_funct3),     64'((m_instr >> 12) & 32'h7));
        check("out_rd",         64'(out_rd),         64'((m_instr >> 7) & 32'h1F));
        check("out_rs1",        64'(out_rs1),        64'((m_instr >> 15) & 32'h1F));
        check("out_rs2",        64'(out_rs2),        64'((m_instr >> 20) & 32'h1F));
        check("out_imm",        64'(out_imm),        m_imm);
        check("out_type",       64'(out_type),       64'(m_type));
        check("out_illegal",    64'(out_illegal),    64'(m_ill));
        check("out_misaligned", 64'(out_misaligned), 64'(m_mis));
    endtask

    logic [6:0] ops [12] = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h67, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h53, 7'h0B};

    initial begin
        logic [31:0]     w;
        logic [XLEN-1:0] rp;
        reset = 1'b1; imem_valid = 1'b0; imem_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        m_pc = RESET_PC; m_valid = 1'b0; m_out_pc = '0; m_instr = '0;
        m_type = '0; m_imm = '0; m_ill = 1'b0; m_mis = 1'b0;

        // Reset held three cycles while memory offers a word.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h0050_0093, 1'b0, '0, 1'b1);
            check("rst_valid", 64'(out_valid), 64'h0);
            check("rst_addr",  64'(imem_addr), 64'(RESET_PC));
        end

        // Stream of two words.
        cyc(1'b0, 1'b1, 32'h0050_0093, 1'b0, '0, 1'b1);
        check("s0_valid", 64'(out_valid), 64'h1);
        check("s0_pc",    64'(out_pc),    64'h0);
        check("s0_type",  64'(out_type),  64'h02);
        check("s0_imm",   64'(out_imm),   64'h5);
        cyc(1'b0, 1'b1, 32'h0020_8133, 1'b0, '0, 1'b1);
        check("s1_pc",    64'(out_pc),    64'h4);
        check("s1_type",  64'(out_type),  64'h01);
        check("s1_imm",   64'(out_imm),   64'h0);
        check("s1_addr",  64'(imem_addr), 64'h8);

        // Backpressure: held entry and PC stay put, then drain one per cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 32'h0010_0113 + i, 1'b0, '0, 1'b0);
            check("bp_pc",   64'(out_pc),    64'h4);
            check("bp_addr", 64'(imem_addr), 64'h8);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 32'h0010_0113, 1'b0, '0, 1'b1);
            check("drain_pc", 64'(out_pc), 64'(8 + 4 * i));
        end

        // Redirect while stalled flushes the held entry.
        cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_0013, 1'b1, XLEN'(32'h100), 1'b0);
        check("rd_valid", 64'(out_valid), 64'h0);
        check("rd_addr",  64'(imem_addr), 64'h100);
        cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, '0, 1'b1);
        check("rd_pc",    64'(out_pc),    64'h100);

        // PC wrap with a negative branch immediate.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, XLEN'(32'hFFFF_FFFC), 1'b1);
        cyc(1'b0, 1'b1, 32'hFE00_0EE3, 1'b0, '0, 1'b1);
        check("wrap_imm",  64'(out_imm),   64'hFFFF_FFFC);
        check("wrap_type", 64'(out_type),  64'h08);
        check("wrap_addr", 64'(imem_addr), 64'h0);

        // Illegal word, then a misaligned fetch.
        cyc(1'b0, 1'b1, 32'h0000_0000, 1'b0, '0, 1'b1);
        check("ill_flag", 64'(out_illegal), 64'h1);
        check("ill_type", 64'(out_type),    64'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, XLEN'(32'h102), 1'b1);
        cyc(1'b0, 1'b1, 32'h0050_0093, 1'b0, '0, 1'b1);
        check("mis_flag", 64'(out_misaligned), 64'h1);
        check("mis_ill",  64'(out_illegal),    64'h1);

        // Randomized traffic, including reset during stalls.
        for (int i = 0; i < 600; i++) begin
            w = $urandom();
            if ($urandom_range(0, 3) != 0) w = {w[31:7], ops[$urandom_range(0, 11)]};
            rp = XLEN'($urandom());
            if ($urandom_range(0, 7) != 0) rp = rp & ~XLEN'(3);
            if ($urandom_range(0, 9) == 0) rp = XLEN'(32'hFFFF_FFF8);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, w,
                $urandom_range(0, 11) == 0, rp, $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width, legal range 32..64.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded by reset, 4-byte aligned.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  XLEN: fetch address, equal to the current PC register.
REQ-006 SHALL have port imem_data  input  32: instruction word at imem_addr, same cycle.
REQ-007 SHALL have port imem_valid  input  1: imem_data is valid this cycle.
REQ-008 SHALL have port redirect_valid  input  1: branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  XLEN: redirect target.
REQ-010 SHALL have port out_valid  output  1: decoded-instruction register holds a valid entry.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the entry this cycle.
REQ-012 SHALL have ports out_pc (XLEN), out_instr (32), out_opcode (7), out_funct3 (3), out_rd/out_rs1/out_rs2 (5 each), out_imm (XLEN), all outputs, all registered: fields of the held entry.
REQ-013 SHALL have port out_type  output  6: one-hot {j,u,b,s,i,r} instruction type of the held entry.
REQ-014 SHALL have port out_illegal  output  1: held entry failed decode.
REQ-015 SHALL have port out_misaligned  output  1: held entry was fetched from a PC with pc[1:0] != 0.

Function
REQ-016 SHALL define fetch acceptance as accept = imem_valid & ~redirect_valid & (~out_valid | out_ready).
REQ-017 On accept, SHALL load out_* from pc and imem_data and SHALL set out_valid=1 and pc <= pc + 4, modulo 2^XLEN; latency imem_data -> out_* is 1 cycle.
REQ-018 When out_valid & out_ready & ~accept, SHALL clear out_valid.
REQ-019 When out_valid & ~out_ready, SHALL hold pc and all out_* unchanged; imem_data is ignored.
REQ-020 redirect_valid SHALL take priority over everything else: pc <= redirect_pc, out_valid <= 0 (flush, regardless of out_ready), and no fetch is accepted that cycle.
REQ-021 redirect_pc SHALL be loaded unmodified; an entry fetched from a PC with pc[1:0] != 0 SHALL set out_misaligned=1 and out_illegal=1.
REQ-022 Decode SHALL use instr[6:2]: r = 011x0|01011|10100; i = 0000x|001x0|11001; s = 0100x; b = 11000; u = 0x101; j = 11011.
REQ-023 out_illegal SHALL be 1 when instr[1:0] != 2'b11 or no type matches; out_type SHALL then be 0.
REQ-024 out_imm SHALL be sign-extended to XLEN from instr[31]:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}, sign-extended above bit 31
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R or illegal: 0
REQ-025 out_opcode, out_funct3, out_rd, out_rs1 and out_rs2 SHALL be the raw fields instr[6:0], [14:12], [11:7], [19:15] and [24:20].

Reset
REQ-026 While reset=1, SHALL set pc=RESET_PC, out_valid=0, and all other out_* to 0; reset SHALL override redirect and accept.
REQ-027 In the first cycle after reset deasserts, imem_addr SHALL equal RESET_PC, and fetch SHALL proceed per REQ-016.
REQ-028 Reset asserted mid-stall SHALL discard the held entry without it being consumed.

Verification
REQ-029 Reset: hold reset 3 cycles with imem_valid=1 -> out_valid=0 and imem_addr=RESET_PC throughout; first accept occurs the cycle after release.
REQ-030 Stream: out_ready=1, imem_valid=1, words 0x00500093, 0x00208133 -> out_pc 0, 4; out_type 0x02 (i) with out_imm=5, then 0x01 (r) with out_imm=0; imem_addr=8.
REQ-031 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_* and imem_addr stable; raising out_ready yields exactly one handoff per cycle with no loss or duplication.
REQ-032 Redirect: redirect_valid with redirect_pc=0x100 while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and imem_addr=0x100; the next accepted entry has out_pc=0x100.
REQ-033 Wrap and immediates: pc=0xFFFFFFFC (XLEN=32) with instr 0xFE000EE3 (beq, imm -4) -> out_imm=0xFFFFFFFC, out_type=0x08, and next imem_addr=0x00000000.
REQ-034 Illegal and misaligned: instr 0x00000000 -> out_illegal=1 and out_type=0; redirect to 0x102, then fetch -> out_misaligned=1 and out_illegal=1.
